// File: rtl/shift_reg_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_reg_ctrl_if
// Transfer-side bus of the shift-register controller.
//   TX_VALID/TX_READY/TX_DATA : byte handshake into the serializer
//   MSB_FIRST                 : bit order, captured when a byte is accepted
//   STALL / ABORT             : pause or cancel the transfer in progress
//   SIN / SOUT                : serial receive / transmit bit
//   RX_DATA / RX_VALID        : last received byte and its one-cycle strobe
//   BUSY                      : transfer in progress
// master = byte producer/consumer, slave = shift_reg_ctrl.
// ---------------------------------------------------------------------------
interface shift_reg_ctrl_if;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] TX_DATA;
  logic       MSB_FIRST;
  logic       STALL;
  logic       ABORT;
  logic       SIN;
  logic       SOUT;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       BUSY;

  modport master (
    output TX_VALID, TX_DATA, MSB_FIRST, STALL, ABORT, SIN,
    input  TX_READY, SOUT, RX_DATA, RX_VALID, BUSY
  );

  modport slave (
    input  TX_VALID, TX_DATA, MSB_FIRST, STALL, ABORT, SIN,
    output TX_READY, SOUT, RX_DATA, RX_VALID, BUSY
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// ---------------------------------------------------------------------------
// shift_reg_ctrl
// Drives an external 8-bit universal shift register to send one byte and
// receive one byte simultaneously. A byte is parallel-loaded into the
// register, shifted out 8 times (SOUT taken from the outgoing end, SIN fed
// into the incoming end), and the register contents are then latched as the
// received byte.
// Ports:
//   CLK  : clock, all state changes on the rising edge
//   CLRb : asynchronous active-low reset
//   bus  : transfer bus (shift_reg_ctrl_if.slave)
//   S    : register mode (11 load, 10 shift up from SDL, 01 shift down from SDR, 00 hold)
//   D    : parallel load data, 8'h00 unless loading
//   SDL  : serial input into bit 0 when shifting up
//   SDR  : serial input into bit 7 when shifting down
//   Q    : current register contents
// ---------------------------------------------------------------------------
module shift_reg_ctrl (
  input  logic                  CLK,
  input  logic                  CLRb,
  shift_reg_ctrl_if.slave       bus,
  output logic [1:0]            S,
  output logic [7:0]            D,
  output logic                  SDL,
  output logic                  SDR,
  input  logic [7:0]            Q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_UP    = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       dir_r;
  logic       dir_nxt_s;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       rx_capture_s;

  logic [1:0] s_s;
  logic [7:0] d_s;
  logic       sdl_s;
  logic       sdr_s;
  logic       sout_s;
  logic       tx_ready_s;
  logic       busy_s;

  // Next-state, counter/direction update and all combinational outputs
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    dir_nxt_s    = dir_r;
    rx_capture_s = 1'b0;
    s_s          = MODE_HOLD;
    d_s          = 8'h00;
    sdl_s        = 1'b0;
    sdr_s        = 1'b0;
    sout_s       = 1'b0;
    tx_ready_s   = 1'b0;
    busy_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_ready_s = 1'b1;
        // ABORT is deliberately ignored here: an offered byte is always taken
        if (bus.TX_VALID) begin
          s_s         = MODE_LOAD;
          d_s         = bus.TX_DATA;
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = 3'd0;
          dir_nxt_s   = bus.MSB_FIRST;
        end else begin
          s_s = MODE_HOLD;
        end
      end

      ST_SHIFT: begin
        busy_s = 1'b1;
        sdl_s  = bus.SIN;
        sdr_s  = bus.SIN;
        sout_s = dir_r ? Q[7] : Q[0];
        if (bus.ABORT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 3'd0;
        end else if (bus.STALL) begin
          s_s = MODE_HOLD;
        end else begin
          s_s       = dir_r ? MODE_UP : MODE_DOWN;
          cnt_nxt_s = cnt_r + 3'd1;
          // The eighth shift wraps CNT back to 0 on its way to DONE
          if (cnt_r == 3'd7) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
      end

      ST_DONE: begin
        busy_s = 1'b1;
        sout_s = dir_r ? Q[7] : Q[0];
        if (bus.ABORT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s  = ST_IDLE;
          rx_capture_s = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      dir_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  // Received byte latch and its one-cycle strobe
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_capture_s;
      if (rx_capture_s) begin
        rx_data_r <= Q;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign S            = s_s;
  assign D            = d_s;
  assign SDL          = sdl_s;
  assign SDR          = sdr_s;
  assign bus.SOUT     = sout_s;
  assign bus.TX_READY = tx_ready_s;
  assign bus.BUSY     = busy_s;
  assign bus.RX_DATA  = rx_data_r;
  assign bus.RX_VALID = rx_valid_r;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_ctrl
// Bench for shift_reg_ctrl. Contains a behavioural model of the external
// universal shift register; expected received bytes and their arrival cycle
// are queued when a byte is offered and checked when RX_VALID pulses.
// ---------------------------------------------------------------------------
module tb_shift_reg_ctrl;

  logic       CLK = 1'b0;
  logic       CLRb = 1'b0;
  logic [1:0] S;
  logic [7:0] D;
  logic       SDL;
  logic       SDR;
  logic [7:0] Q = 8'h00;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  shift_reg_ctrl_if bif ();

  shift_reg_ctrl dut (
    .CLK  (CLK),
    .CLRb (CLRb),
    .bus  (bif),
    .S    (S),
    .D    (D),
    .SDL  (SDL),
    .SDR  (SDR),
    .Q    (Q)
  );

  always #5 CLK = ~CLK;

  // Edge counter used for latency stamps
  always @(posedge CLK) cyc <= cyc + 1;

  // External shift register model
  always @(posedge CLK) begin
    case (S)
      2'b11:   Q <= D;
      2'b10:   Q <= {Q[6:0], SDL};
      2'b01:   Q <= {SDR, Q[7:1]};
      default: Q <= Q;
    endcase
  end

  // Scoreboard: every RX_VALID pulse must match the oldest expected byte and cycle
  always @(negedge CLK) begin
    if (CLRb && bif.RX_VALID) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: RX_VALID pulse at cycle %0d data %h, none expected", cyc, bif.RX_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bif.RX_DATA !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL rx_scoreboard: got data %h at cycle %0d, want data %h at cycle %0d",
                   bif.RX_DATA, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one transfer. stall_after/abort_after index the shift before which
  // the event happens (-1 = none, abort_after 8 = abort in DONE). Returns the
  // observed SOUT sequence (first bit in bit 7), counts of bad control cycles,
  // and the accept edge number. Leaves time in the cycle after the final edge.
  task automatic run_xfer(input logic [7:0] tx, input logic msb, input logic [7:0] rxb,
                          input int stall_after, input int stall_len, input int abort_after,
                          input logic keep_valid, output logic [7:0] sout_v,
                          output int s_bad, output int stall_bad, output int acc_cyc);
    logic hold_v;
    sout_v    = 8'h00;
    s_bad     = 0;
    stall_bad = 0;
    bif.TX_VALID  = 1'b1;
    bif.TX_DATA   = tx;
    bif.MSB_FIRST = msb;
    #1;
    if (S !== 2'b11 || D !== tx || bif.TX_READY !== 1'b1) s_bad++;
    acc_cyc = cyc + 1;
    if (abort_after < 0)
      exp_q.push_back('{rxb, cyc + 10 + ((stall_after >= 0) ? stall_len : 0)});
    @(posedge CLK); #1;
    bif.ABORT = 1'b0;
    if (!keep_valid) bif.TX_VALID = 1'b0;
    bif.MSB_FIRST = ~msb;
    for (int i = 0; i < 8; i++) begin
      if (abort_after == i) begin
        bif.ABORT = 1'b1;
        #1;
        if (S !== 2'b00) s_bad++;
        @(posedge CLK); #1;
        bif.ABORT = 1'b0;
        return;
      end
      if (stall_after == i) begin
        hold_v = bif.SOUT;
        for (int k = 0; k < stall_len; k++) begin
          bif.STALL = 1'b1;
          #1;
          if (S !== 2'b00 || bif.SOUT !== hold_v || bif.BUSY !== 1'b1) stall_bad++;
          @(posedge CLK); #1;
        end
        bif.STALL = 1'b0;
      end
      bif.SIN = msb ? rxb[7-i] : rxb[i];
      #1;
      sout_v[7-i] = bif.SOUT;
      if (S !== (msb ? 2'b10 : 2'b01) || SDL !== bif.SIN || SDR !== bif.SIN ||
          D !== 8'h00 || bif.BUSY !== 1'b1 || bif.TX_READY !== 1'b0) s_bad++;
      @(posedge CLK); #1;
    end
    if (S !== 2'b00 || SDL !== 1'b0 || bif.BUSY !== 1'b1 || bif.TX_READY !== 1'b0) s_bad++;
    if (abort_after == 8) begin
      bif.ABORT = 1'b1;
      #1;
      if (S !== 2'b00) s_bad++;
      @(posedge CLK); #1;
      bif.ABORT = 1'b0;
      return;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    logic [23:0] got_v;
    logic [23:0] exp_v;
    repeat (2) @(posedge CLK);
    #1;
    got_v = {bif.TX_READY, bif.BUSY, bif.SOUT, SDL, SDR, S, D, bif.RX_VALID, bif.RX_DATA};
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", got_v, exp_v);
    end
    CLRb = 1'b1;
  endtask

  task automatic test_msb_first();
    logic [7:0] sv; int sb; int tb; int ac;
    run_xfer(8'hA5, 1'b1, 8'h3C, -1, 0, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (sv !== 8'hA5) begin n_fail++; $display("FAIL msb_sout: got %h want %h", sv, 8'hA5); end
    n_cmp++;
    if (sb !== 0) begin n_fail++; $display("FAIL msb_ctrl: %0d bad control cycles, want 0", sb); end
    n_cmp++;
    if (bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h3C || cyc - ac !== 9) begin
      n_fail++;
      $display("FAIL msb_rx: valid %b data %h lat %0d want 1 3c 9", bif.RX_VALID, bif.RX_DATA, cyc - ac);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] sv; int sb; int tb; int ac;
    run_xfer(8'h01, 1'b0, 8'h80, -1, 0, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (sv !== 8'h80) begin n_fail++; $display("FAIL lsb_sout: got %h want %h", sv, 8'h80); end
    n_cmp++;
    if (sb !== 0) begin n_fail++; $display("FAIL lsb_ctrl: %0d bad control cycles, want 0", sb); end
    n_cmp++;
    if (bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h80) begin
      n_fail++;
      $display("FAIL lsb_rx: valid %b data %h want 1 80", bif.RX_VALID, bif.RX_DATA);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (bif.RX_VALID !== 1'b0 || bif.RX_DATA !== 8'h80) begin
      n_fail++;
      $display("FAIL lsb_pulse_width: valid %b data %h want 0 80", bif.RX_VALID, bif.RX_DATA);
    end
  endtask

  task automatic test_abort_in_idle();
    logic [7:0] sv; int sb; int tb; int ac;
    bif.ABORT = 1'b1;
    run_xfer(8'h81, 1'b1, 8'h7E, -1, 0, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (sv !== 8'h81 || sb !== 0) begin
      n_fail++;
      $display("FAIL abort_idle_xfer: sout %h bad %0d want 81 0", sv, sb);
    end
    n_cmp++;
    if (bif.RX_DATA !== 8'h7E) begin n_fail++; $display("FAIL abort_idle_rx: got %h want 7e", bif.RX_DATA); end
  endtask

  task automatic test_stall();
    logic [7:0] sv; int sb; int tb; int ac;
    run_xfer(8'h96, 1'b1, 8'h69, 4, 3, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (tb !== 0) begin n_fail++; $display("FAIL stall_hold: %0d bad stall cycles, want 0", tb); end
    n_cmp++;
    if (sv !== 8'h96 || sb !== 0) begin
      n_fail++;
      $display("FAIL stall_sout: sout %h bad %0d want 96 0", sv, sb);
    end
    n_cmp++;
    if (bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h69 || cyc - ac !== 12) begin
      n_fail++;
      $display("FAIL stall_rx: valid %b data %h lat %0d want 1 69 12", bif.RX_VALID, bif.RX_DATA, cyc - ac);
    end
  endtask

  task automatic test_abort();
    logic [7:0] sv; int sb; int tb; int ac;
    logic [7:0] prev_v;
    prev_v = bif.RX_DATA;
    run_xfer(8'hFF, 1'b1, 8'h55, -1, 0, 5, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (bif.TX_READY !== 1'b1 || bif.BUSY !== 1'b0 || bif.RX_VALID !== 1'b0 || sb !== 0) begin
      n_fail++;
      $display("FAIL abort_shift_idle: ready %b busy %b valid %b bad %0d want 1 0 0 0",
               bif.TX_READY, bif.BUSY, bif.RX_VALID, sb);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (bif.RX_DATA !== prev_v) begin n_fail++; $display("FAIL abort_rx_keep: got %h want %h", bif.RX_DATA, prev_v); end
    run_xfer(8'h3A, 1'b0, 8'hC5, -1, 0, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (sv !== 8'h5C || sb !== 0 || bif.RX_DATA !== 8'hC5) begin
      n_fail++;
      $display("FAIL abort_next_xfer: sout %h bad %0d rx %h want 5c 0 c5", sv, sb, bif.RX_DATA);
    end
    run_xfer(8'h11, 1'b1, 8'h22, -1, 0, 8, 1'b0, sv, sb, tb, ac);
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (bif.RX_DATA !== 8'hC5 || bif.TX_READY !== 1'b1 || sb !== 0) begin
      n_fail++;
      $display("FAIL abort_done: rx %h ready %b bad %0d want c5 1 0", bif.RX_DATA, bif.TX_READY, sb);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sv1; logic [7:0] sv2; int sb1; int sb2; int tb; int ac1; int ac2;
    run_xfer(8'hF0, 1'b1, 8'h12, -1, 0, -1, 1'b1, sv1, sb1, tb, ac1);
    n_cmp++;
    if (bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h12 || bif.TX_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_rx: valid %b data %h ready %b want 1 12 1", bif.RX_VALID, bif.RX_DATA, bif.TX_READY);
    end
    run_xfer(8'h0F, 1'b1, 8'h34, -1, 0, -1, 1'b0, sv2, sb2, tb, ac2);
    n_cmp++;
    if (ac2 - ac1 !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 10", ac2 - ac1); end
    n_cmp++;
    if (sv1 !== 8'hF0 || sv2 !== 8'h0F || sb1 !== 0 || sb2 !== 0) begin
      n_fail++;
      $display("FAIL b2b_sout: %h %h bad %0d %0d want f0 0f 0 0", sv1, sv2, sb1, sb2);
    end
    n_cmp++;
    if (bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h34) begin
      n_fail++;
      $display("FAIL b2b_second_rx: valid %b data %h want 1 34", bif.RX_VALID, bif.RX_DATA);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] sv; int sb; int tb; int ac;
    logic [23:0] got_v;
    logic [23:0] exp_v;
    bif.TX_VALID  = 1'b1;
    bif.TX_DATA   = 8'hAA;
    bif.MSB_FIRST = 1'b1;
    @(posedge CLK); #1;
    bif.TX_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.SIN = 1'b1;
      @(posedge CLK); #1;
    end
    bif.SIN = 1'b1;
    #1;
    CLRb = 1'b0;
    #1;
    got_v = {bif.TX_READY, bif.BUSY, bif.SOUT, SDL, SDR, S, D, bif.RX_VALID, bif.RX_DATA};
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", got_v, exp_v);
    end
    @(posedge CLK); #1;
    CLRb = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    run_xfer(8'hC3, 1'b1, 8'h5E, -1, 0, -1, 1'b0, sv, sb, tb, ac);
    n_cmp++;
    if (sv !== 8'hC3 || sb !== 0 || bif.RX_VALID !== 1'b1 || bif.RX_DATA !== 8'h5E) begin
      n_fail++;
      $display("FAIL reset_next_xfer: sout %h bad %0d valid %b rx %h want c3 0 1 5e",
               sv, sb, bif.RX_VALID, bif.RX_DATA);
    end
  endtask

  initial begin
    bif.TX_VALID  = 1'b0;
    bif.TX_DATA   = 8'h00;
    bif.MSB_FIRST = 1'b1;
    bif.STALL     = 1'b0;
    bif.ABORT     = 1'b0;
    bif.SIN       = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_abort_in_idle();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rx_outstanding: %0d expected bytes never received, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Port CLK input 1 SHALL be the single clock; all state changes occur on its rising edge.
REQ-002 Port CLRb input 1 SHALL be an asynchronous, active-low reset.
REQ-003 Port TX_VALID input 1 SHALL indicate that TX_DATA holds a byte to transfer.
REQ-004 Port TX_READY output 1 SHALL indicate that the controller accepts a byte this cycle.
REQ-005 Port TX_DATA input 8 SHALL be the parallel byte to serialize.
REQ-006 Port MSB_FIRST input 1 SHALL select bit order (1 = MSB first, 0 = LSB first) and is sampled at accept.
REQ-007 Port STALL input 1 SHALL pause shifting while high.
REQ-008 Port ABORT input 1 SHALL cancel the current transfer synchronously.
REQ-009 Port SIN input 1 SHALL be the serial receive bit.
REQ-010 Port SOUT output 1 SHALL be the serial transmit bit.
REQ-011 Port RX_DATA output 8 SHALL hold the last received byte.
REQ-012 Port RX_VALID output 1 SHALL be a one-cycle pulse marking a new RX_DATA.
REQ-013 Port BUSY output 1 SHALL be high while a transfer is in progress.
REQ-014 Ports S output 2, D output 8, SDL output 1 and SDR output 1 SHALL drive an 8-bit shift register. Its modes are 11 = load D, 10 = shift toward bit 7 with SDL into bit 0, 01 = shift toward bit 0 with SDR into bit 7, and 00 = hold.
REQ-015 Port Q input 8 SHALL be the shift register's current contents.

Function
REQ-016 The controller SHALL implement the states IDLE, SHIFT and DONE, with a 3-bit shift counter CNT and a stored direction bit DIR.
REQ-017 In IDLE, TX_READY SHALL be 1 and BUSY SHALL be 0. In SHIFT and DONE, TX_READY SHALL be 0 and BUSY SHALL be 1.
REQ-018 In IDLE with TX_VALID=1, S SHALL be 11 and D SHALL equal TX_DATA (combinational). On that edge the register loads, DIR<=MSB_FIRST, CNT<=0 and the state goes to SHIFT.
REQ-019 In IDLE with TX_VALID=0, S SHALL be 00. D SHALL be 8'h00 whenever S is not 11.
REQ-020 In SHIFT with STALL=0, S SHALL be 10 if DIR=1 and 01 if DIR=0.
REQ-021 In SHIFT, SDL and SDR SHALL both equal SIN. Outside SHIFT, SDL and SDR SHALL be 0.
REQ-022 SOUT SHALL equal Q[7] when DIR=1 and Q[0] when DIR=0 in SHIFT and DONE, and SHALL be 0 in IDLE.
REQ-023 In SHIFT with STALL=0, CNT SHALL increment on each edge. The edge at which CNT=7 SHALL move the state to DONE, giving exactly 8 shifts.
REQ-024 In SHIFT with STALL=1, S SHALL be 00 and CNT and state SHALL hold. SOUT SHALL remain stable.
REQ-025 In DONE, S SHALL be 00. On the DONE edge, RX_DATA<=Q, RX_VALID<=1 and the state goes to IDLE.
REQ-026 RX_VALID SHALL be high for exactly one cycle, the first IDLE cycle after DONE. RX_DATA SHALL hold its value until the next DONE edge.
REQ-027 Latency SHALL be: accept edge 0, shift edges 1-8, DONE edge 9, RX_VALID high in cycle 10 (with no STALL). Each STALL cycle adds one.
REQ-028 A new byte MAY be accepted in the RX_VALID cycle (back-to-back transfers, 10 cycles per byte).
REQ-029 ABORT=1 in SHIFT or DONE SHALL force S=00 and return the state to IDLE on that edge. In that case RX_VALID SHALL NOT pulse, RX_DATA SHALL be unchanged, and CNT SHALL be 0.
REQ-030 ABORT SHALL take priority over STALL and over DONE completion. ABORT in IDLE SHALL have no effect, and TX_VALID SHALL still be accepted.
REQ-031 MSB_FIRST changes after accept SHALL NOT affect the transfer in progress.

Reset
REQ-032 CLRb=0 SHALL asynchronously set state=IDLE, CNT=0, DIR=1, RX_DATA=8'h00 and RX_VALID=0. The outputs SHALL then read TX_READY=1, BUSY=0, SOUT=0, SDL=SDR=0, D=8'h00, and S=00 while TX_VALID=0.
REQ-033 A reset asserted mid-transfer SHALL abandon the transfer with no RX_VALID pulse. The first accept after CLRb rises SHALL start a clean 8-shift transfer.

Verification
REQ-034 MSB_FIRST=1, TX_DATA=8'hA5, SIN driven with 8'h3C MSB first -> SOUT sequence 1,0,1,0,0,1,0,1; RX_DATA=8'h3C; RX_VALID in cycle 10.
REQ-035 MSB_FIRST=0, TX_DATA=8'h01, SIN driven with 8'h80 LSB first -> SOUT sequence 1,0,0,0,0,0,0,0; RX_DATA=8'h80; S=01 during all shifts.
REQ-036 STALL held for 3 cycles after shift 4 -> S=00 and SOUT stable for those 3 cycles; RX_VALID in cycle 13; received byte correct.
REQ-037 ABORT after shift 5 -> IDLE on the next cycle; no RX_VALID pulse; RX_DATA keeps its previous value; the next byte transfers correctly.
REQ-038 Two bytes 8'hF0 and 8'h0F with TX_VALID held high -> second accept in the RX_VALID cycle; two RX_VALID pulses 10 cycles apart.
REQ-039 CLRb pulsed low during shift 3 -> outputs at reset values immediately, without waiting for a CLK edge; no RX_VALID pulse; a subsequent 8'hC3 transfer completes normally.
